// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared writeback-select, load funct3 and wb-stage state encodings
package pipeline_pkg;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;
    localparam logic [1:0] WB_SEL_CSR = 2'd3;

    localparam logic [2:0] FUNCT3_LB  = 3'd0;
    localparam logic [2:0] FUNCT3_LH  = 3'd1;
    localparam logic [2:0] FUNCT3_LW  = 3'd2;
    localparam logic [2:0] FUNCT3_LBU = 3'd4;
    localparam logic [2:0] FUNCT3_LHU = 3'd5;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        READY   = 2'd1,
        LD_WAIT = 2'd2,
        LD_DONE = 2'd3
    } wb_state_t;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - combinational load byte/half select with sign or zero extension
module load_align
    import pipeline_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_din,
    output logic [XLEN-1:0] o_dout
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_din[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_din[7:0];
            2'd1:    w_byte = i_din[15:8];
            2'd2:    w_byte = i_din[23:16];
            default: w_byte = i_din[31:24];
        endcase
        // Halfword lane comes from addr bit 1 only; misaligned bit 0 is ignored.
        w_half = i_addr_lo[1] ? i_din[31:16] : i_din[15:0];
    end

    always_comb begin
        o_dout = i_din;
        case (i_funct3)
            FUNCT3_LB:  o_dout = {{(XLEN-8){w_byte[7]}}, w_byte};
            FUNCT3_LH:  o_dout = {{(XLEN-16){w_half[15]}}, w_half};
            FUNCT3_LBU: o_dout = {{(XLEN-8){1'b0}}, w_byte};
            FUNCT3_LHU: o_dout = {{(XLEN-16){1'b0}}, w_half};
            default:    o_dout = i_din;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - stage-3 writeback with load wait/buffer; optional bypass via WB_FWD_EN
module wb_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_in,
    input  logic              s2_valid,
    input  logic [REG_AW-1:0] s2_rd,
    input  logic              s2_we,
    input  logic [1:0]        s2_wb_sel,
    input  logic [XLEN-1:0]   s2_alu_result,
    input  logic [XLEN-1:0]   s2_pc_plus4,
    input  logic [2:0]        s2_funct3,
    input  logic [XLEN-1:0]   dcache_dout,
    input  logic              dcache_stall,
    output logic [REG_AW-1:0] rd,
    output logic              we,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_busy,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [XLEN-1:0]   fwd_data
);

    wb_state_t         r_state;
    wb_state_t         w_state_nxt;
    logic              r_valid;
    logic [REG_AW-1:0] r_rd;
    logic              r_we;
    logic [1:0]        r_wb_sel;
    logic [XLEN-1:0]   r_alu_result;
    logic [XLEN-1:0]   r_pc_plus4;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;
    logic [XLEN-1:0]   r_ld_buf;

    logic              w_adv;
    logic              w_ld_capture;
    logic [XLEN-1:0]   w_ld_aligned;
    logic [XLEN-1:0]   w_mem_data;

    load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .i_funct3  (r_funct3),
        .i_addr_lo (r_addr_lo),
        .i_din     (dcache_dout),
        .o_dout    (w_ld_aligned)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ld_capture = 1'b0;
        wb_busy      = (r_state == LD_WAIT) && dcache_stall;
        w_adv        = !stall_in && !wb_busy;

        // A response that lands under a global stall is parked in ld_buf.
        case (r_state)
            LD_WAIT: begin
                if (!dcache_stall && stall_in) begin
                    w_state_nxt  = LD_DONE;
                    w_ld_capture = 1'b1;
                end
            end
            default: ;
        endcase

        if (w_adv) begin
            if (!s2_valid) begin
                w_state_nxt = EMPTY;
            end else if (s2_wb_sel == WB_SEL_MEM) begin
                w_state_nxt = LD_WAIT;
            end else begin
                w_state_nxt = READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid      <= 1'b0;
            r_rd         <= '0;
            r_we         <= 1'b0;
            r_wb_sel     <= WB_SEL_ALU;
            r_alu_result <= '0;
            r_pc_plus4   <= '0;
            r_funct3     <= '0;
            r_addr_lo    <= '0;
        end else if (w_adv) begin
            r_valid      <= s2_valid;
            r_rd         <= s2_rd;
            r_we         <= s2_we;
            r_wb_sel     <= s2_wb_sel;
            r_alu_result <= s2_alu_result;
            r_pc_plus4   <= s2_pc_plus4;
            r_funct3     <= s2_funct3;
            r_addr_lo    <= s2_alu_result[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ld_buf <= '0;
        end else if (w_ld_capture) begin
            r_ld_buf <= w_ld_aligned;
        end
    end

    // Gating on w_adv makes each instruction write exactly once, on its leaving edge.
    assign we = r_valid && r_we && (r_rd != '0) && w_adv;
    assign rd = r_rd;

    assign w_mem_data = (r_state == LD_DONE) ? r_ld_buf : w_ld_aligned;

    always_comb begin
        wb_data = r_alu_result;
        case (r_wb_sel)
            WB_SEL_MEM: wb_data = w_mem_data;
            WB_SEL_PC4: wb_data = r_pc_plus4;
            default:    wb_data = r_alu_result;
        endcase
    end

`ifdef WB_FWD_EN
    assign fwd_valid = r_valid && r_we && (r_rd != '0) && (r_state != LD_WAIT);
    assign fwd_rd    = r_rd;
    assign fwd_data  = wb_data;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

endmodule
